// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two CPU requesters, the arbiter and the shared RAM.
//   slave  : arbiter view. Requests and RAM read data come in; acks, read data
//            and the registered RAM strobes go out.
//   master : environment view. Both requesters plus the RAM itself drive the
//            arbiter inputs and observe its outputs.
// Signals:
//   req0/req1      access request, held until the matching ack
//   addr0/addr1    byte address, stable while the request is high
//   wmask0/wmask1  byte write enables, all zero means read
//   wdata0/wdata1  write data, stable while the request is high
//   ack0/ack1      one-cycle completion pulse
//   rdata          read data, valid in the ack cycle
//   mem_en         one-cycle RAM access strobe
//   mem_addr       RAM address
//   mem_wmask      RAM byte write enables
//   mem_wdata      RAM write data
//   mem_rdata      RAM read data
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    logic                  req0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [MASK_WIDTH-1:0] wmask0;
    logic [MASK_WIDTH-1:0] wmask1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MASK_WIDTH-1:0] mem_wmask;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, addr0, addr1, wmask0, wmask1, wdata0, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata,
        output mem_en, mem_addr, mem_wmask, mem_wdata
    );

    modport master (
        output req0, req1, addr0, addr1, wmask0, wmask1, wdata0, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata,
        input  mem_en, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous single-port RAM between CPU instruction fetch (port 0)
// and CPU load/store (port 1). Round-robin arbitration; each access runs
// IDLE -> ISSUE -> WAIT -> DONE: latch request into the RAM strobes, pulse
// mem_en, wait MEM_LATENCY cycles, capture read data and pulse the ack.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   mem_bus_arbiter_if slave modport (requests, acks, RAM side)
// Every output comes straight from a flop.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(MEM_LATENCY - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic                  last_q,      last_d;
    logic                  gnt_q,       gnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
    logic                  ack0_q,      ack0_d;
    logic                  ack1_q,      ack1_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic                  mem_en_q,    mem_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [MASK_WIDTH-1:0] mem_wmask_q, mem_wmask_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  winner;

    // Lone requester wins outright; on a tie the port not served last wins.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            winner = ~last_q;
        end else begin
            winner = bus.req1;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wmask_d = mem_wmask_q;
        mem_wdata_d = mem_wdata_q;
        // Strobes default low so each is a single-cycle pulse.
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        mem_en_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d       = winner;
                    last_d      = winner;
                    cnt_d       = CNT_INIT;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = winner ? bus.addr1  : bus.addr0;
                    mem_wmask_d = winner ? bus.wmask1 : bus.wmask0;
                    mem_wdata_d = winner ? bus.wdata1 : bus.wdata0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.mem_rdata;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_DONE: begin
                mem_wmask_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. dut_a (MEM_LATENCY=1) talks to a small
// RAM model; dut_b (MEM_LATENCY=3) has its RAM read data driven cycle by cycle
// so the capture cycle is visible. Inputs driven and outputs sampled on the
// falling edge.
module tb_mem_bus_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_ack0;
    int   n_ack1;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // RAM model for dut_a: 64 words, read-before-write, registered read data.
    logic [31:0] ram [0:63];

    function automatic logic [31:0] init_word(input int unsigned i);
        case (i)
            4:       return 32'hDEADBEEF;
            8:       return 32'hFFFFFFFF;
            default: return 32'hA5000000 + i;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (bus_a.mem_en) begin
            bus_a.mem_rdata <= ram[bus_a.mem_addr[7:2]];
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus_a.mem_wmask[b])
                    ram[bus_a.mem_addr[7:2]][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on dut_a, started at the falling edge of an IDLE cycle t.
    // Returns at the falling edge of t+4, again an IDLE cycle.
    task automatic access_a(input string tag, input logic port, input logic [31:0] addr,
                            input logic [3:0] wmask, input logic [31:0] wdata,
                            input logic chk_rd, input logic [31:0] exp_rd,
                            input logic drop_early);
        if (port) begin
            bus_a.req1 = 1'b1; bus_a.addr1 = addr; bus_a.wmask1 = wmask; bus_a.wdata1 = wdata;
        end else begin
            bus_a.req0 = 1'b1; bus_a.addr0 = addr; bus_a.wmask0 = wmask; bus_a.wdata0 = wdata;
        end
        @(negedge clk); // t+1
        chk1 ({tag, ".en1"},    bus_a.mem_en, 1'b1);
        chk32({tag, ".addr"},   bus_a.mem_addr, addr);
        chk32({tag, ".wmask"},  32'(bus_a.mem_wmask), 32'(wmask));
        if (wmask != 4'b0000) chk32({tag, ".wdata"}, bus_a.mem_wdata, wdata);
        chk1 ({tag, ".ack0_1"}, bus_a.ack0, 1'b0);
        chk1 ({tag, ".ack1_1"}, bus_a.ack1, 1'b0);
        if (drop_early) begin
            bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        end
        @(negedge clk); // t+2
        chk1 ({tag, ".en2"},    bus_a.mem_en, 1'b0);
        chk1 ({tag, ".ack0_2"}, bus_a.ack0, 1'b0);
        chk1 ({tag, ".ack1_2"}, bus_a.ack1, 1'b0);
        @(negedge clk); // t+3
        chk1 ({tag, ".ack0_3"}, bus_a.ack0, ~port);
        chk1 ({tag, ".ack1_3"}, bus_a.ack1, port);
        chk1 ({tag, ".en3"},    bus_a.mem_en, 1'b0);
        if (chk_rd) chk32({tag, ".rdata"}, bus_a.rdata, exp_rd);
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        @(negedge clk); // t+4
        chk1 ({tag, ".ack0_4"}, bus_a.ack0, 1'b0);
        chk1 ({tag, ".ack1_4"}, bus_a.ack1, 1'b0);
        chk1 ({tag, ".en4"},    bus_a.mem_en, 1'b0);
        chk32({tag, ".wmask0"}, 32'(bus_a.mem_wmask), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus_a.req0 = 1'b1;   bus_a.req1 = 1'b1;
        bus_a.addr0 = 32'h04; bus_a.addr1 = 32'h08;
        bus_a.wmask0 = 4'h0; bus_a.wmask1 = 4'h0;
        bus_a.wdata0 = '0;   bus_a.wdata1 = '0;
        bus_b.req0 = 1'b0;   bus_b.req1 = 1'b0;
        bus_b.addr0 = '0;    bus_b.addr1 = '0;
        bus_b.wmask0 = 4'h0; bus_b.wmask1 = 4'h0;
        bus_b.wdata0 = '0;   bus_b.wdata1 = '0;
        bus_b.mem_rdata = '0;

        // Reset held two cycles with both requests high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1 ("rst.ack0",   bus_a.ack0, 1'b0);
        chk1 ("rst.ack1",   bus_a.ack1, 1'b0);
        chk1 ("rst.en",     bus_a.mem_en, 1'b0);
        chk32("rst.wmask",  32'(bus_a.mem_wmask), 32'h0);
        chk32("rst.addr",   bus_a.mem_addr, 32'h0);
        chk32("rst.wdata",  bus_a.mem_wdata, 32'h0);
        chk32("rst.rdata",  bus_a.rdata, 32'h0);
        chk1 ("rst.b_en",   bus_b.mem_en, 1'b0);
        chk1 ("rst.b_ack0", bus_b.ack0, 1'b0);
        rst = 1'b0;

        // Continuous contention for 8 accesses: port 0 first, then alternate,
        // one access every 4 cycles.
        n_ack0 = 0;
        n_ack1 = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            chk1("arb.en",   bus_a.mem_en, (c % 4) == 1);
            chk1("arb.ack0", bus_a.ack0, ((c % 4) == 3) && (((c / 4) % 2) == 0));
            chk1("arb.ack1", bus_a.ack1, ((c % 4) == 3) && (((c / 4) % 2) == 1));
            if ((c % 4) == 1)
                chk32("arb.addr", bus_a.mem_addr, (((c / 4) % 2) == 0) ? 32'h04 : 32'h08);
            if ((c % 4) == 3)
                chk32("arb.rdata", bus_a.rdata,
                      (((c / 4) % 2) == 0) ? 32'hA5000001 : 32'hA5000002);
            if (bus_a.ack0) n_ack0++;
            if (bus_a.ack1) n_ack1++;
            if (c == 31) begin
                bus_a.req0 = 1'b0;
                bus_a.req1 = 1'b0;
            end
        end
        chk32("arb.n_ack0", 32'(n_ack0), 32'd4);
        chk32("arb.n_ack1", 32'(n_ack1), 32'd4);

        // Single read, write with partial mask, read-back, early request drop.
        access_a("rd0",   1'b0, 32'h10, 4'b0000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
        access_a("wr1",   1'b1, 32'h20, 4'b0011, 32'h12345678, 1'b0, 32'h0,        1'b0);
        access_a("rd1",   1'b1, 32'h20, 4'b0000, 32'h0,        1'b1, 32'hFFFF5678, 1'b0);
        access_a("drop1", 1'b1, 32'h24, 4'b0000, 32'h0,        1'b1, 32'hA5000009, 1'b1);

        // Reset during WAIT abandons the access; the held request is reissued.
        bus_a.req0 = 1'b1; bus_a.addr0 = 32'h10; bus_a.wmask0 = 4'h0;  // t
        @(negedge clk);                                                // t+1
        chk1("mid.en1", bus_a.mem_en, 1'b1);
        @(negedge clk);                                                // t+2
        chk1("mid.ack0_2", bus_a.ack0, 1'b0);
        rst = 1'b1;
        @(negedge clk);                                                // t+3
        chk1 ("mid.ack0_3", bus_a.ack0, 1'b0);
        chk1 ("mid.en3",    bus_a.mem_en, 1'b0);
        chk32("mid.rdata0", bus_a.rdata, 32'h0);
        chk32("mid.addr0",  bus_a.mem_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);                                                // t+4
        chk1 ("mid.en4",   bus_a.mem_en, 1'b1);
        chk32("mid.addr4", bus_a.mem_addr, 32'h10);
        @(negedge clk);                                                // t+5
        chk1("mid.ack0_5", bus_a.ack0, 1'b0);
        @(negedge clk);                                                // t+6
        chk1 ("mid.ack0_6", bus_a.ack0, 1'b1);
        chk1 ("mid.ack1_6", bus_a.ack1, 1'b0);
        chk32("mid.rdata",  bus_a.rdata, 32'hDEADBEEF);
        bus_a.req0 = 1'b0;
        @(negedge clk);                                                // t+7
        chk1("mid.ack0_7", bus_a.ack0, 1'b0);

        // MEM_LATENCY=3: ack at t+5 carrying the RAM data seen in cycle t+4.
        bus_b.req0 = 1'b1; bus_b.addr0 = 32'h10; bus_b.mem_rdata = 32'h00000000;  // t
        @(negedge clk);                                                            // t+1
        chk1 ("l3.en1",  bus_b.mem_en, 1'b1);
        chk32("l3.addr", bus_b.mem_addr, 32'h10);
        bus_b.mem_rdata = 32'h00000001;
        @(negedge clk);                                                            // t+2
        chk1("l3.en2",   bus_b.mem_en, 1'b0);
        chk1("l3.ack_2", bus_b.ack0, 1'b0);
        bus_b.mem_rdata = 32'h00000002;
        @(negedge clk);                                                            // t+3
        chk1("l3.ack_3", bus_b.ack0, 1'b0);
        bus_b.mem_rdata = 32'h00000003;
        @(negedge clk);                                                            // t+4
        chk1("l3.ack_4", bus_b.ack0, 1'b0);
        bus_b.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);                                                            // t+5
        chk1 ("l3.ack_5",  bus_b.ack0, 1'b1);
        chk1 ("l3.ack1_5", bus_b.ack1, 1'b0);
        chk32("l3.rdata",  bus_b.rdata, 32'hCAFEF00D);
        bus_b.mem_rdata = 32'h00000005;
        bus_b.req0 = 1'b0;
        @(negedge clk);                                                            // t+6
        chk1("l3.ack_6", bus_b.ack0, 1'b0);
        chk1("l3.en6",   bus_b.mem_en, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
